// File: rtl/icache_store_assoc.sv
// rtl/icache_store_assoc.sv - N-way set-associative instruction-cache tag/data store with line-fill engine
// Registered lookup with per-word select; fill victim is the lowest invalid way, else the per-set round-robin pointer.
`ifndef L1_TAG_WIDTH
`define L1_TAG_WIDTH 20
`endif
`ifndef L1_INDEX_WIDTH
`define L1_INDEX_WIDTH 6
`endif
`ifndef L1_ICACHE_DATA_WIDTH
`define L1_ICACHE_DATA_WIDTH 64
`endif

module icache_store_assoc #(
   parameter int WAYS        = 2,
   parameter int TAG_WIDTH   = `L1_TAG_WIDTH,
   parameter int INDEX_WIDTH = `L1_INDEX_WIDTH,
   parameter int WORDS       = 8,
   parameter int DATA_WIDTH  = `L1_ICACHE_DATA_WIDTH,
   localparam int OFF_W      = $clog2(WORDS) + 3,
   localparam int A_W        = TAG_WIDTH + INDEX_WIDTH + OFF_W,
   localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             lkp_valid,
   input  logic [A_W-1:0]                   lkp_addr,
   output logic                             lkp_ready,
   output logic                             rsp_valid,
   output logic                             rsp_hit,
   output logic                             rsp_err,
   output logic [WAY_W-1:0]                 rsp_way,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   input  logic                             fill_req_valid,
   input  logic [TAG_WIDTH+INDEX_WIDTH-1:0] fill_req_addr,
   output logic                             fill_req_ready,
   input  logic                             fill_wr_valid,
   input  logic [DATA_WIDTH-1:0]            fill_wr_data,
   output logic                             fill_wr_ready,
   output logic                             fill_done,
   output logic                             busy
);

   localparam int SETS  = 1 << INDEX_WIDTH;
   localparam int CNT_W = $clog2(WORDS);

   typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, INV = 2'd2} state_t;

   state_t state, next_state;

   logic [DATA_WIDTH-1:0] data_mem [WAYS][SETS][WORDS];
   logic [TAG_WIDTH-1:0]  tag_mem  [WAYS][SETS];
   logic                  valid    [WAYS][SETS];
   logic [WAY_W-1:0]      rr_ptr   [SETS];

   logic [TAG_WIDTH-1:0]   f_tag;
   logic [INDEX_WIDTH-1:0] f_idx;
   logic [WAY_W-1:0]       f_way;
   logic                   f_rr;
   logic [CNT_W-1:0]       cnt;

   logic [TAG_WIDTH-1:0]   lkp_tag;
   logic [INDEX_WIDTH-1:0] lkp_index;
   logic [OFF_W-1:0]       lkp_off;
   logic [CNT_W-1:0]       lkp_word;
   logic                   lkp_fire, lkp_misal, lkp_hit;
   logic [WAY_W-1:0]       lkp_way;

   logic [TAG_WIDTH-1:0]   req_tag;
   logic [INDEX_WIDTH-1:0] req_index;
   logic [WAY_W-1:0]       vic_way;
   logic                   vic_rr;
   logic                   req_fire, wr_fire, wr_last;

   assign lkp_tag   = lkp_addr[A_W-1 -: TAG_WIDTH];
   assign lkp_index = lkp_addr[OFF_W +: INDEX_WIDTH];
   assign lkp_off   = lkp_addr[OFF_W-1:0];
   assign lkp_word  = lkp_off[OFF_W-1:3];
   assign lkp_misal = |lkp_off[2:0];
   assign lkp_fire  = lkp_valid & lkp_ready;

   assign req_tag   = fill_req_addr[TAG_WIDTH+INDEX_WIDTH-1 -: TAG_WIDTH];
   assign req_index = fill_req_addr[INDEX_WIDTH-1:0];
   assign req_fire  = fill_req_valid & fill_req_ready;
   assign wr_fire   = fill_wr_valid & fill_wr_ready;
   assign wr_last   = (cnt == CNT_W'(WORDS - 1));

   assign busy = (state != IDLE);

   // Descending scan so the lowest matching way is the one left standing.
   always_comb begin
      lkp_hit = 1'b0;
      lkp_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[w][lkp_index] && (tag_mem[w][lkp_index] == lkp_tag)) begin
            lkp_hit = 1'b1;
            lkp_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      vic_way = rr_ptr[req_index];
      vic_rr  = (WAYS > 1);
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w][req_index]) begin
            vic_way = WAY_W'(w);
            vic_rr  = 1'b0;
         end
      end
   end

   always_comb begin
      next_state     = state;
      fill_req_ready = 1'b0;
      lkp_ready      = 1'b0;
      fill_wr_ready  = 1'b0;
      case (state)
         IDLE: begin
            fill_req_ready = 1'b1;
            lkp_ready      = ~fill_req_valid;
            if (fill_req_valid) next_state = FILL;
         end
         FILL: begin
            fill_wr_ready = 1'b1;
            if (fill_wr_valid && wr_last) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         f_tag     <= '0;
         f_idx     <= '0;
         f_way     <= '0;
         f_rr      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_way   <= '0;
         rsp_data  <= '0;
         fill_done <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            rr_ptr[s] <= '0;
            for (int w = 0; w < WAYS; w++) valid[w][s] <= 1'b0;
         end
      end else begin
         state     <= next_state;
         rsp_valid <= lkp_fire;
         rsp_err   <= lkp_fire & lkp_misal;
         rsp_hit   <= lkp_fire & ~lkp_misal & lkp_hit;
         rsp_way   <= (lkp_fire && !lkp_misal && lkp_hit) ? lkp_way : '0;
         rsp_data  <= (lkp_fire && !lkp_misal && lkp_hit) ?
                      data_mem[lkp_way][lkp_index][lkp_word] : '0;
         fill_done <= wr_fire & wr_last;

         if (req_fire) begin
            f_tag <= req_tag;
            f_idx <= req_index;
            f_way <= vic_way;
            f_rr  <= vic_rr;
            cnt   <= '0;
            valid[vic_way][req_index] <= 1'b0;
         end

         if (wr_fire) begin
            cnt <= cnt + CNT_W'(1);
            if (wr_last) begin
               valid[f_way][f_idx] <= 1'b1;
               if (f_rr) begin
                  rr_ptr[f_idx] <= (rr_ptr[f_idx] == WAY_W'(WAYS - 1)) ?
                                   '0 : rr_ptr[f_idx] + WAY_W'(1);
               end
            end
         end
      end
   end

   // Arrays carry no reset; validity is tracked solely by the valid bits.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         data_mem[f_way][f_idx][cnt] <= fill_wr_data;
         if (wr_last) tag_mem[f_way][f_idx] <= f_tag;
      end
   end

endmodule

// File: tb/tb_icache_store_assoc.sv
// tb/tb_icache_store_assoc.sv - self-checking bench for icache_store_assoc
module tb_icache_store_assoc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lkp_valid;
   logic [17:0] lkp_addr;
   logic        lkp_ready;
   logic        rsp_valid, rsp_hit, rsp_err;
   logic [0:0]  rsp_way;
   logic [63:0] rsp_data;
   logic        fill_req_valid;
   logic [11:0] fill_req_addr;
   logic        fill_req_ready;
   logic        fill_wr_valid;
   logic [63:0] fill_wr_data;
   logic        fill_wr_ready;
   logic        fill_done;
   logic        busy;

   icache_store_assoc #(
      .WAYS(2), .TAG_WIDTH(8), .INDEX_WIDTH(4), .WORDS(8), .DATA_WIDTH(64)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .lkp_valid(lkp_valid), .lkp_addr(lkp_addr), .lkp_ready(lkp_ready),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
      .rsp_way(rsp_way), .rsp_data(rsp_data),
      .fill_req_valid(fill_req_valid), .fill_req_addr(fill_req_addr),
      .fill_req_ready(fill_req_ready),
      .fill_wr_valid(fill_wr_valid), .fill_wr_data(fill_wr_data),
      .fill_wr_ready(fill_wr_ready),
      .fill_done(fill_done), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        hit;
      logic        err;
      logic        way;
      logic [63:0] data;
   } exp_t;

   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   run_cmp = 0;
   exp_t expq[$];

   // Behavioural cache model: contents by (way, set), plus replacement pointer per set.
   logic        mv [2][16];
   logic [7:0]  mt [2][16];
   logic [63:0] md [2][16][8];
   int          mrr [16];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [17:0] mk(input logic [7:0] tag, input logic [3:0] idx,
                                     input logic [5:0] off);
      return {tag, idx, off};
   endfunction

   function automatic exp_t predict(input logic [17:0] a);
      exp_t        e;
      logic [7:0]  tag;
      logic [3:0]  idx;
      logic [5:0]  off;
      tag = a[17:10];
      idx = a[9:6];
      off = a[5:0];
      e.cyc  = 0;
      e.err  = (off[2:0] != 3'd0);
      e.hit  = 1'b0;
      e.way  = 1'b0;
      e.data = '0;
      if (!e.err) begin
         for (int w = 0; w < 2; w++) begin
            if (!e.hit && mv[w][idx] && mt[w][idx] == tag) begin
               e.hit  = 1'b1;
               e.way  = w[0];
               e.data = md[w][idx][off[5:3]];
            end
         end
      end
      return e;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 16; s++) begin
         mrr[s] = 0;
         for (int w = 0; w < 2; w++) mv[w][s] = 1'b0;
      end
      expq.delete();
   endtask

   always @(negedge clk) begin
      if (run_cmp) begin
         if (expq.size() > 0 && expq[0].cyc == cyc) begin
            exp_t e;
            e = expq.pop_front();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_hit", rsp_hit, e.hit);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_way", rsp_way, e.way);
            chk("rsp_data", rsp_data, e.data);
         end else begin
            chk("rsp_idle", rsp_valid, 0);
         end
      end
   end

   // Called at a falling edge; presents one lookup for one cycle.
   task automatic do_lookup(input logic [17:0] a, input bit pin, input logic l_hit,
                            input logic l_err, input logic l_way, input logic [63:0] l_data);
      exp_t e;
      lkp_valid = 1'b1;
      lkp_addr  = a;
      #1;
      chk("lkp_ready", lkp_ready, 1);
      e = predict(a);
      e.cyc = cyc + 1;
      if (pin) begin
         chk("model_hit", e.hit, l_hit);
         chk("model_err", e.err, l_err);
         chk("model_way", e.way, l_way);
         chk("model_data", e.data, l_data);
      end
      expq.push_back(e);
      @(negedge clk);
      lkp_valid = 1'b0;
   endtask

   task automatic do_fill(input logic [7:0] tag, input logic [3:0] idx, input logic [63:0] base,
                          input bit gap, input bit also_lkp, input int abort_n);
      int w;
      int n;
      int it;
      bit rr_used;
      fill_req_valid = 1'b1;
      fill_req_addr  = {tag, idx};
      if (also_lkp) begin
         lkp_valid = 1'b1;
         lkp_addr  = mk(tag, idx, 6'h00);
      end
      #1;
      chk("fill_req_ready", fill_req_ready, 1);
      if (also_lkp) chk("lkp_ready_vs_fill", lkp_ready, 0);
      w = -1;
      for (int k = 0; k < 2; k++) if (w < 0 && !mv[k][idx]) w = k;
      rr_used = (w < 0);
      if (rr_used) w = mrr[idx];
      mv[w][idx] = 1'b0;
      @(negedge clk);
      fill_req_valid = 1'b0;
      lkp_valid      = 1'b0;
      n  = 0;
      it = 0;
      while (n < 8 && !(abort_n > 0 && n == abort_n) && it < 40) begin
         fill_wr_valid = gap ? ((it % 2) == 0) : 1'b1;
         fill_wr_data  = base + 64'(n);
         #1;
         chk("busy_in_fill", busy, 1);
         chk("lkp_ready_in_fill", lkp_ready, 0);
         chk("fill_done_early", fill_done, 0);
         chk("fill_wr_ready", fill_wr_ready, 1);
         if (fill_wr_valid && fill_wr_ready) begin
            md[w][idx][n] = fill_wr_data;
            n++;
         end
         it++;
         @(negedge clk);
      end
      fill_wr_valid = 1'b0;
      if (it >= 40) chk("fill_timeout", 1, 0);
      if (abort_n > 0) begin
         rst_n = 1'b0;
         #1;
         chk("busy_after_abort", busy, 0);
         chk("rsp_valid_after_abort", rsp_valid, 0);
         model_reset();
         @(negedge clk);
         rst_n = 1'b1;
         #1;
         chk("busy_after_release", busy, 0);
      end else begin
         #1;
         chk("fill_done", fill_done, 1);
         chk("busy_done", busy, 0);
         chk("lkp_ready_done", lkp_ready, 1);
         mt[w][idx] = tag;
         mv[w][idx] = 1'b1;
         if (rr_used) mrr[idx] = (mrr[idx] + 1) % 2;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      lkp_valid = 1'b0;
      lkp_addr = '0;
      fill_req_valid = 1'b0;
      fill_req_addr = '0;
      fill_wr_valid = 1'b0;
      fill_wr_data = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_hit", rsp_hit, 0);
      chk("reset_rsp_err", rsp_err, 0);
      chk("reset_rsp_way", rsp_way, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_fill_done", fill_done, 0);
      chk("reset_busy", busy, 0);
      chk("reset_lkp_ready", lkp_ready, 1);
      chk("reset_fill_req_ready", fill_req_ready, 1);
      run_cmp = 1;
      @(negedge clk);

      do_lookup(mk(8'h05, 4'd3, 6'h08), 1, 0, 0, 0, 64'h0);

      // Lookup issued in the fill_done cycle must already hit.
      do_fill(8'h05, 4'd3, 64'h100, 0, 0, 0);
      do_lookup(mk(8'h05, 4'd3, 6'h10), 1, 1, 0, 0, 64'h102);

      do_fill(8'h0A, 4'd1, 64'hA00, 0, 0, 0);
      do_fill(8'h0B, 4'd1, 64'hB00, 0, 0, 0);
      do_fill(8'h0C, 4'd1, 64'hC00, 0, 0, 0);
      do_lookup(mk(8'h0A, 4'd1, 6'h00), 1, 0, 0, 0, 64'h0);
      do_lookup(mk(8'h0B, 4'd1, 6'h00), 1, 1, 0, 1, 64'hB00);
      do_lookup(mk(8'h0C, 4'd1, 6'h38), 1, 1, 0, 0, 64'hC07);

      do_fill(8'h0D, 4'd1, 64'hD00, 0, 0, 0);
      do_lookup(mk(8'h0B, 4'd1, 6'h00), 1, 0, 0, 0, 64'h0);
      do_lookup(mk(8'h0D, 4'd1, 6'h08), 1, 1, 0, 1, 64'hD01);
      do_lookup(mk(8'h0C, 4'd1, 6'h18), 1, 1, 0, 0, 64'hC03);

      do_lookup(mk(8'h05, 4'd3, 6'h0C), 1, 0, 1, 0, 64'h0);

      do_fill(8'h22, 4'd7, 64'h700, 1, 1, 0);
      do_lookup(mk(8'h22, 4'd7, 6'h20), 1, 1, 0, 0, 64'h704);

      for (int k = 0; k < 8; k++) begin
         do_lookup(mk((k % 2 == 0) ? 8'h0C : 8'h22, (k % 2 == 0) ? 4'd1 : 4'd7,
                      6'(k * 8 + ((k == 5) ? 1 : 0))), 0, 0, 0, 0, 64'h0);
      end

      do_fill(8'h33, 4'd9, 64'h900, 0, 0, 4);
      @(negedge clk);
      do_lookup(mk(8'h33, 4'd9, 6'h00), 1, 0, 0, 0, 64'h0);
      do_lookup(mk(8'h05, 4'd3, 6'h10), 1, 0, 0, 0, 64'h0);

      repeat (2) @(negedge clk);
      if (expq.size() != 0) chk("responses_outstanding", 64'(expq.size()), 0);
      run_cmp = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
